// File: rtl/mac_source_addrgen_if.sv
// Word-address stream from the address generator toward the memory-request path.
// Every cycle in which valid and ready are both high moves one address.
interface mac_source_addrgen_if #(
    parameter int AW = 32
) ();
    logic [AW-1:0] addr;
    logic          valid;
    logic          ready;

    modport master (output addr, output valid, input ready);
    modport slave  (input addr, input valid, output ready);
endinterface

// File: rtl/mac_source_addrgen.sv
// Per-stream address generator: takes a start request with base address and
// line geometry, then issues one word address per valid/ready handshake.
//
//   state | meaning
//   IDLE  | ready_start_o high; waits for req_start_i (an empty transfer only pulses done)
//   RUN   | addr_if.valid high; steps the address on each accepted handshake
module mac_source_addrgen #(
    parameter int AW         = 32,
    parameter int TW         = 16,
    parameter int DATA_BYTES = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  test_mode_i,
    input  logic                  clear_i,
    input  logic                  req_start_i,
    input  logic [AW-1:0]         base_addr_i,
    input  logic [TW-1:0]         trans_size_i,
    input  logic [TW-1:0]         line_length_i,
    input  logic [AW-1:0]         line_stride_i,
    mac_source_addrgen_if.master  addr_if,
    output logic                  ready_start_o,
    output logic                  done_o,
    output logic [TW-1:0]         cnt_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] line_base_q, line_base_d;
    logic [AW-1:0] stride_q, stride_d;
    logic [TW-1:0] trans_q, trans_d;
    logic [TW-1:0] line_len_q, line_len_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] word_idx_q, word_idx_d;
    logic          done_q, done_d;

    logic [TW-1:0] line_len_eff;
    logic [AW-1:0] stride_eff;
    logic [AW-1:0] next_line;
    logic          hs;

    wire unused_test_mode = test_mode_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            line_base_q <= '0;
            stride_q    <= '0;
            trans_q     <= '0;
            line_len_q  <= '0;
            cnt_q       <= '0;
            word_idx_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            line_base_q <= line_base_d;
            stride_q    <= stride_d;
            trans_q     <= trans_d;
            line_len_q  <= line_len_d;
            cnt_q       <= cnt_d;
            word_idx_q  <= word_idx_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        line_base_d = line_base_q;
        stride_d    = stride_q;
        trans_d     = trans_q;
        line_len_d  = line_len_q;
        cnt_d       = cnt_q;
        word_idx_d  = word_idx_q;
        done_d      = 1'b0;

        // Zero line length means a single line; zero stride means packed lines.
        line_len_eff = (line_length_i == '0) ? trans_size_i : line_length_i;
        stride_eff   = (line_stride_i == '0) ? AW'(line_len_eff) * AW'(DATA_BYTES)
                                             : line_stride_i;
        next_line    = line_base_q + stride_q;
        hs           = (state_q == RUN) && addr_if.ready;

        if (clear_i) begin
            state_d     = IDLE;
            addr_d      = '0;
            line_base_d = '0;
            stride_d    = '0;
            trans_d     = '0;
            line_len_d  = '0;
            cnt_d       = '0;
            word_idx_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_start_i) begin
                        trans_d     = trans_size_i;
                        line_len_d  = line_len_eff;
                        stride_d    = stride_eff;
                        addr_d      = base_addr_i;
                        line_base_d = base_addr_i;
                        cnt_d       = '0;
                        word_idx_d  = '0;
                        if (trans_size_i == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (hs) begin
                        cnt_d = cnt_q + TW'(1);
                        if (word_idx_q == line_len_q - TW'(1)) begin
                            word_idx_d  = '0;
                            line_base_d = next_line;
                            addr_d      = next_line;
                        end else begin
                            word_idx_d = word_idx_q + TW'(1);
                            addr_d     = addr_q + AW'(DATA_BYTES);
                        end
                        if (cnt_q == trans_q - TW'(1)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign addr_if.addr  = addr_q;
    assign addr_if.valid = (state_q == RUN);
    assign ready_start_o = (state_q == IDLE);
    assign done_o        = done_q;
    assign cnt_o         = cnt_q;

endmodule
